// File: rtl/spi_mpu_set.sv
// rtl/spi_mpu_set.sv - SPI mode-3 master issuing a single 16-bit register write to an MPU-class sensor.
module spi_mpu_set #(
  parameter int CLK_DIV   = 3,
  parameter int HOLD_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miso,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       sclk,
  output logic       busy,
  output logic       finish,
  output logic       mosi
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD_PRE,
    XFER,
    HOLD_POST,
    DONE
  } state_t;

  state_t               state;
  logic                 start_q;
  logic [15:0]          shreg;
  logic [CLK_DIV-1:0]   phase_cnt;
  logic [HOLD_BITS-1:0] hold_cnt;
  logic [3:0]           bit_cnt;

  // Writes never look at the slave's reply or the caller's R/W bit.
  logic unused_ok;
  assign unused_ok = ^{miso, addr[7]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      shreg     <= '0;
      phase_cnt <= '0;
      hold_cnt  <= '0;
      bit_cnt   <= '0;
      sclk      <= 1'b1;
      mosi      <= 1'b1;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      start_q <= start;
      finish  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          sclk <= 1'b1;
          mosi <= 1'b1;
          if (start && !start_q) begin
            shreg    <= {1'b0, addr[6:0], data};
            hold_cnt <= '0;
            busy     <= 1'b1;
            state    <= HOLD_PRE;
          end
        end
        HOLD_PRE: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == '1) begin
            // First falling edge carries the R/W bit out immediately.
            sclk      <= 1'b0;
            mosi      <= shreg[15];
            shreg     <= {shreg[14:0], 1'b0};
            phase_cnt <= '0;
            bit_cnt   <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          phase_cnt <= phase_cnt + 1'b1;
          if (phase_cnt == '1) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_cnt == 4'd15) begin
              mosi     <= 1'b1;
              hold_cnt <= '0;
              state    <= HOLD_POST;
            end else begin
              sclk    <= 1'b0;
              mosi    <= shreg[15];
              shreg   <= {shreg[14:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        HOLD_POST: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == '1) begin
            finish <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          sclk  <= 1'b1;
          mosi  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mpu_set.sv
// tb/tb_spi_mpu_set.sv - bench for spi_mpu_set: transaction-level timeline model plus directed literal checks.
module tb_spi_mpu_set;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic       miso  = 1'b1;
  logic [7:0] addr  = 8'h00;
  logic [7:0] data  = 8'h00;
  logic       sclk, busy, finish, mosi;

  spi_mpu_set dut (
    .clk(clk), .rst(rst), .start(start), .miso(miso), .addr(addr), .data(data),
    .sclk(sclk), .busy(busy), .finish(finish), .mosi(mosi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: a transaction is a fixed 289-cycle timeline indexed by cycles since accept.
  bit          m_active = 1'b0;
  bit          m_prev   = 1'b0;
  int          m_k      = 0;
  logic [15:0] m_word   = 16'h0;

  logic [15:0] cap        = 16'h0;
  logic [15:0] exp_stream = 16'h0;
  int          nbits      = 0;
  int          busy_len   = 0;
  int          finish_cnt = 0;
  logic        last_sclk  = 1'b1;
  logic        last_busy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_idle;
    if (!rst) begin
      m_active = 1'b0;
      m_prev   = 1'b0;
    end else begin
      was_idle = !m_active;
      if (m_active) begin
        m_k++;
        if (m_k > 288) m_active = 1'b0;
      end
      if (was_idle && start && !m_prev) begin
        m_active = 1'b1;
        m_k      = 0;
        m_word   = {1'b0, addr[6:0], data};
      end
      m_prev = start;
    end
  endtask

  task automatic compare();
    logic e_sclk, e_mosi, e_busy, e_fin;
    int   p;
    e_sclk = 1'b1;
    e_mosi = 1'b1;
    e_busy = 1'b0;
    e_fin  = 1'b0;
    if (rst && m_active) begin
      e_busy = 1'b1;
      e_fin  = (m_k == 288);
      if (m_k >= 16 && m_k < 272) begin
        p      = m_k - 16;
        e_sclk = ((p % 16) >= 8);
        e_mosi = m_word[15 - p / 16];
      end
    end
    check("outputs{sclk,mosi,busy,finish}", 32'({sclk, mosi, busy, finish}),
          32'({e_sclk, e_mosi, e_busy, e_fin}));

    if (!rst) begin
      busy_len = 0;
      nbits    = 0;
    end else begin
      if (busy && !last_busy) begin
        nbits    = 0;
        cap      = 16'h0;
        busy_len = 0;
      end
      if (busy) busy_len++;
      if (busy && sclk && !last_sclk) begin
        cap = {cap[14:0], mosi};
        nbits++;
      end
      if (finish) begin
        finish_cnt++;
        check("stream", 32'(cap), 32'(exp_stream));
        check("nbits", 32'(nbits), 32'd16);
      end
      if (!busy && last_busy) check("busy_len", 32'(busy_len), 32'd289);
    end
    last_sclk = sclk;
    last_busy = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_finish(input int budget);
    int n;
    n = 0;
    while (finish !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("finish_seen", 32'(finish), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (5) tick();
    check("reset_out", 32'({sclk, mosi, busy, finish}), 32'b1100);
    rst = 1'b1;
    repeat (3) tick();

    // Write B7/55, start held 3 cycles; mid-XFER start pulse and input change must not matter.
    addr = 8'hB7; data = 8'h55; exp_stream = 16'h3755;
    start = 1'b1;
    repeat (3) tick();
    check("busy_after_accept", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (100) tick();
    start = 1'b1; addr = 8'hFF; data = 8'hFF;
    tick();
    start = 1'b0;
    wait_finish(400);

    // Back-to-back: start rises in the cycle right after DONE.
    tick();
    addr = 8'h6B; data = 8'h80; exp_stream = 16'h6B80;
    start = 1'b1;
    tick();
    check("b2b_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_finish(400);
    check("finish_count_2", 32'(finish_cnt), 32'd2);

    // Reset mid-XFER: immediate idle outputs and no finish.
    repeat (4) tick();
    addr = 8'h12; data = 8'h34;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    #2 rst = 1'b0;
    #1 check("abort_out", 32'({sclk, mosi, busy, finish}), 32'b1100);
    repeat (3) tick();
    rst = 1'b1;
    repeat (350) tick();
    check("finish_after_abort", 32'(finish_cnt), 32'd2);

    // Recovery transaction after abort.
    addr = 8'h80; data = 8'hFF; exp_stream = 16'h00FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_finish(400);
    repeat (3) tick();
    check("finish_count_3", 32'(finish_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
